// File: rtl/adc_spi_responder.sv
// adc_spi_responder: oversampled 24-bit SPI configuration responder with an
// 8-bit register file, frame status outputs and sticky framing error flags.
module adc_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_REGS    = 16,
    localparam int unsigned AW         = $clog2(NUM_REGS)
) (
    input  logic          CLK,
    input  logic          RSTb,
    input  logic          CSb,
    input  logic          SCLK,
    input  logic          SDA,
    input  logic [AW-1:0] REG_ADDR,
    output logic [7:0]    REG_DATA,
    input  logic          CLR_ERR,
    output logic          FRAME_STROBE,
    output logic [23:0]   FRAME_WORD,
    output logic [15:0]   FRAME_CNT,
    output logic          ERR_SHORT,
    output logic          ERR_LONG
);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t state, nextState;

    logic [SYNC_STAGES-1:0] csSync, sclkSync, sdaSync;
    logic                   csPrev, sclkPrev;
    logic                   csS, sclkS, sdaS;
    logic                   csFall, csRise, sclkRise;

    logic [SYNC_STAGES:0]   flushSr;
    logic                   armed;
    logic                   pendFall;

    logic [4:0]             bitCnt;
    logic [23:0]            shreg;
    logic                   ovf;

    logic                   startFrame, shiftEn, ovfSet, isDone;
    logic                   accept, setShort, setLong, doWrite;
    logic [12:0]            frameAddr;
    logic [AW-1:0]          wAddr;

    logic [7:0]             regs [NUM_REGS];

    assign csS   = csSync[SYNC_STAGES-1];
    assign sclkS = sclkSync[SYNC_STAGES-1];
    assign sdaS  = sdaSync[SYNC_STAGES-1];

    assign csFall   =  csPrev & ~csS;
    assign csRise   = ~csPrev &  csS;
    assign sclkRise = ~sclkPrev & sclkS;

    // Synchronizer chains plus history flops for edge detection
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            csSync   <= '1;
            sclkSync <= '1;
            sdaSync  <= '0;
            csPrev   <= 1'b1;
            sclkPrev <= 1'b1;
        end else begin
            csSync   <= {csSync[SYNC_STAGES-2:0], CSb};
            sclkSync <= {sclkSync[SYNC_STAGES-2:0], SCLK};
            sdaSync  <= {sdaSync[SYNC_STAGES-2:0], SDA};
            csPrev   <= csS;
            sclkPrev <= sclkS;
        end
    end

    // Arm frame detection only once CSb has been seen high through a flushed
    // synchronizer, so a CSb already low at reset release is not a frame start
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            flushSr <= '0;
            armed   <= 1'b0;
        end else begin
            flushSr <= {flushSr[SYNC_STAGES-1:0], 1'b1};
            armed   <= armed | (flushSr[SYNC_STAGES] & csS);
        end
    end

    // Remember a csFall seen during DONE so IDLE can take it next cycle
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb)
            pendFall <= 1'b0;
        else if (state == IDLE)
            pendFall <= 1'b0;
        else if (state == DONE && csFall)
            pendFall <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb)
            state <= IDLE;
        else
            state <= nextState;
    end

    // FSM next-state and per-cycle datapath controls
    always_comb begin
        nextState  = state;
        startFrame = 1'b0;
        shiftEn    = 1'b0;
        ovfSet     = 1'b0;
        isDone     = 1'b0;
        case (state)
            IDLE: begin
                if (armed && (csFall || pendFall)) begin
                    startFrame = 1'b1;
                    nextState  = RECV;
                end
            end
            RECV: begin
                if (sclkRise) begin
                    if (bitCnt < 5'd24)
                        shiftEn = 1'b1;
                    else
                        ovfSet = 1'b1;
                end
                if (csRise)
                    nextState = DONE;
            end
            DONE: begin
                isDone    = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Bit counter, shift register and overflow flag
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            bitCnt <= '0;
            shreg  <= '0;
            ovf    <= 1'b0;
        end else if (startFrame) begin
            bitCnt <= '0;
            shreg  <= '0;
            ovf    <= 1'b0;
        end else if (shiftEn) begin
            shreg  <= {shreg[22:0], sdaS};
            bitCnt <= bitCnt + 5'd1;
        end else if (ovfSet) begin
            ovf <= 1'b1;
        end
    end

    assign frameAddr = shreg[20:8];
    assign wAddr     = shreg[8 +: AW];
    assign accept    = isDone && (bitCnt == 5'd24) && !ovf;
    assign setLong   = isDone && ovf;
    assign setShort  = isDone && !ovf && (bitCnt != 5'd24);
    assign doWrite   = accept && !shreg[23] && (shreg[22:21] == 2'b00)
                       && (frameAddr < 13'(NUM_REGS));

    // Frame status outputs and sticky error flags (set beats clear)
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            FRAME_STROBE <= 1'b0;
            FRAME_WORD   <= '0;
            FRAME_CNT    <= '0;
            ERR_SHORT    <= 1'b0;
            ERR_LONG     <= 1'b0;
        end else begin
            FRAME_STROBE <= accept;
            if (accept) begin
                FRAME_WORD <= shreg;
                FRAME_CNT  <= FRAME_CNT + 16'd1;
            end
            ERR_SHORT <= (ERR_SHORT & ~CLR_ERR) | setShort;
            ERR_LONG  <= (ERR_LONG  & ~CLR_ERR) | setLong;
        end
    end

    // Register file write port
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (doWrite) begin
            regs[wAddr] <= shreg[7:0];
        end
    end

    // Registered readback
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb)
            REG_DATA <= '0;
        else
            REG_DATA <= regs[REG_ADDR];
    end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Serial configuration responder for the ADC chip-select/clock/data link. It receives 24-bit frames, MSB first, sampled on SCLK rising edges, from the FPGA-side ADC configuration master, and decodes them into an 8-bit register file. It also reports frame status to the VME user side. It sits on the test/emulation board in place of one ADC's configuration port, or in the bench as a checking model. All logic runs in the CLK domain; the serial pins are oversampled.

## Interface
- SYNC_STAGES, 2, synchronizer flops on CSb/SCLK/SDA (min 2)
- NUM_REGS, 16, register-file depth (power of two, ≤ 256)
- CLK  in  1  system clock, ≥ 4× SCLK frequency
- RSTb  in  1  reset, asynchronous, active-low; clock CLK
- CSb  in  1  frame select, active-low, asynchronous to CLK
- SCLK  in  1  serial clock, idles high, asynchronous
- SDA  in  1  serial data, changes on SCLK falling edge
- REG_ADDR  in  log2(NUM_REGS)  register readback address
- REG_DATA  out  8  register readback data, registered
- CLR_ERR  in  1  clears ERR_SHORT/ERR_LONG (synchronous pulse)
- FRAME_STROBE  out  1  one-CLK pulse per accepted 24-bit frame
- FRAME_WORD  out  24  last accepted frame, held until the next one
- FRAME_CNT  out  16  accepted-frame counter, wraps 0xFFFF→0
- ERR_SHORT  out  1  sticky: frame ended with fewer than 24 bits
- ERR_LONG  out  1  sticky: more than 24 SCLK rises inside one frame

## Operation
- Frame format: [23] R/Wb (0 = write), [22:21] W1:W0 byte count (must be 00), [20:8] address, [7:0] data.
- Input path: CSb, SCLK and SDA each pass through SYNC_STAGES flops plus one history flop. All three use equal depth so SDA stays aligned with its SCLK edge.
- Events are defined on synchronized signals: csFall, csRise, sclkRise.
- State IDLE: wait for csFall, then clear BitCnt (5 bits) and Shreg (24 bits), clear the overflow flag, go to RECV.
- State RECV: on sclkRise with BitCnt < 24, shift Shreg ← {Shreg[22:0], SDA} and increment BitCnt. On sclkRise with BitCnt = 24, set the overflow flag; Shreg is not modified.
- State RECV, on csRise, go to DONE.
- Same-cycle sclkRise and csRise: the bit IS shifted in before DONE is evaluated. The master raises SCLK for bit 0 on the same edge that deasserts CSb, so this case is the normal case.
- State DONE (one cycle), return to IDLE:
  - BitCnt = 24 and no overflow: load FRAME_WORD, pulse FRAME_STROBE, increment FRAME_CNT. Write reg[addr] ← data if R/Wb = 0, W = 00 and address < NUM_REGS. Otherwise no write, but the frame still counts as accepted.
  - BitCnt < 24: set ERR_SHORT; no strobe, no write. csFall directly followed by csRise with BitCnt = 0 also sets ERR_SHORT.
  - Overflow: set ERR_LONG; no strobe, no write.
- csFall while in DONE is taken on the following IDLE cycle. Back-to-back frames separated by ≥ 2 CLK of CSb high must both be received.
- sclkRise while CSb is high is ignored.
- CLR_ERR clears both error flags. If CLR_ERR arrives in the same cycle that DONE sets a flag, the set wins.
- REG_DATA ← reg[REG_ADDR] every CLK. A same-cycle write to the addressed register shows the old value, and the new value one cycle later.

## Timing
- Reset values: REG_DATA 0, FRAME_STROBE 0, FRAME_WORD 0, FRAME_CNT 0, ERR_SHORT 0, ERR_LONG 0, all registers 0, state IDLE. All synchronizer flops reset high except SDA, which resets to 0.
- Latency from the physical csRise edge to FRAME_STROBE is SYNC_STAGES + 2 CLK (±1 for metastability resolution). FRAME_WORD, FRAME_CNT and the register write all update in the same cycle as FRAME_STROBE.
- Minimum SCLK high and low time is 2 CLK periods. Minimum CSb-high time between frames is 2 CLK periods.
- Reset asserted mid-frame aborts the frame with no strobe and no error. After release, if CSb is already low, the block waits for a fresh csFall; no partial frame is received.

## Test plan
- Write frame 0x000305 (reg 3 ← 0x05), SCLK = CLK/8 -> one FRAME_STROBE, FRAME_WORD = 0x000305, FRAME_CNT = 1; REG_ADDR = 3 gives REG_DATA = 0x05.
- Master-accurate timing, with the 24th SCLK rise coincident with CSb rising, frame 0x000AA5 -> reg 10 = 0xA5, no errors.
- 20-bit frame, then CSb rises -> ERR_SHORT = 1, no strobe, registers unchanged; CLR_ERR pulse -> ERR_SHORT = 0.
- 26 SCLK rises in one frame -> ERR_LONG = 1, FRAME_CNT unchanged.
- Read frame 0x800377 and out-of-range write 0x001011 -> 2 strobes, FRAME_CNT += 2, no register written.
- RSTb pulse after bit 12 of a frame, then a full frame 0x000142 -> all outputs 0 after reset; reg 1 = 0x42, FRAME_CNT = 1.
